life_step: RTL and testbench

Sequential next-generation engine for the Conway board. It consumes the flat board vector that the pattern-drawing stage writes into, then computes one Game of Life generation one row per clock. It presents the result atomically on `state_out`, which the top level feeds back as the new board. The board has dead (non-wrapping) borders, the same clipping rule the drawing stage applies.

---
 rtl/life_step.sv | 126 ++++++++++++
 tb/tb_life_step.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_step.sv
// One Game of Life generation over a MAX_X x MAX_Y board with dead borders.
// The engine computes one row per clock, then commits the whole new board to state_out in a single edge.
module life_step #(
  parameter int MAX_X = 64,
  parameter int MAX_Y = 48
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [MAX_X*MAX_Y-1:0] state_in,
  output logic [MAX_X*MAX_Y-1:0] state_out,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            gen_count,
  output logic [1:0]             dbg_state
);

  // Handshake: start is a request that is sampled only while idle (busy=0) and is never queued.
  // busy is high from the accepting edge through the commit edge.
  // done pulses for exactly one cycle, while the new board is already visible on state_out.

  localparam int ROW_W = (MAX_Y > 1) ? $clog2(MAX_Y) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ROW_W-1:0]   row;
  logic               last_row;
  logic [MAX_X-1:0]   cur [MAX_Y];
  logic [MAX_X-1:0]   nxt [MAX_Y];
  logic [MAX_X+1:0]   pad_up;
  logic [MAX_X+1:0]   pad_mid;
  logic [MAX_X+1:0]   pad_dn;
  logic [MAX_X-1:0]   row_new;

  assign last_row  = (row == ROW_W'(MAX_Y - 1));
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_row) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The rows above and below are zeroed at the top and bottom edges, and a zero column is added
  // on each side. This makes every out-of-board neighbour read as dead without any wrap-around.
  always_comb begin
    pad_up  = '0;
    pad_dn  = '0;
    pad_mid = {1'b0, cur[row], 1'b0};
    if (row != '0) begin
      pad_up = {1'b0, cur[row - ROW_W'(1)], 1'b0};
    end
    if (!last_row) begin
      pad_dn = {1'b0, cur[row + ROW_W'(1)], 1'b0};
    end
  end

  // Cell x sits at padded bit x+1, so its neighbour columns are padded bits x and x+2.
  for (genvar x = 0; x < MAX_X; x++) begin : g_cell
    logic [3:0] cnt;
    assign cnt = {3'b0, pad_up[x]} + {3'b0, pad_up[x+1]} + {3'b0, pad_up[x+2]}
               + {3'b0, pad_mid[x]}                      + {3'b0, pad_mid[x+2]}
               + {3'b0, pad_dn[x]}  + {3'b0, pad_dn[x+1]} + {3'b0, pad_dn[x+2]};
    assign row_new[x] = (cnt == 4'd3) || ((cnt == 4'd2) && pad_mid[x+1]);
  end

  // cur and nxt are working buffers that are never observed before they are written,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      gen_count <= '0;
      row       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int y = 0; y < MAX_Y; y++) begin
              cur[y] <= state_in[y*MAX_X +: MAX_X];
            end
            row  <= '0;
            busy <= 1'b1;
          end
        end
        RUN: begin
          nxt[row] <= row_new;
          if (!last_row) begin
            row <= row + ROW_W'(1);
          end
        end
        COMMIT: begin
          for (int y = 0; y < MAX_Y; y++) begin
            state_out[y*MAX_X +: MAX_X] <= nxt[y];
          end
          gen_count <= gen_count + 16'd1;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_life_step.sv
// Randomised and directed bench for life_step.
// A reference model supplies the expected boards, and a done-driven monitor checks them from a scoreboard queue.
module tb_life_step;

  localparam int MAX_X = 64;
  localparam int MAX_Y = 48;
  localparam int W     = MAX_X * MAX_Y;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] state_in;
  logic [W-1:0] state_out;
  logic         busy;
  logic         done;
  logic [15:0]  gen_count;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [W-1:0] exp_q[$];
  logic [15:0]  exp_gen_q[$];
  int           exp_cyc_q[$];
  logic [15:0]  model_gen;

  life_step #(.MAX_X(MAX_X), .MAX_Y(MAX_Y)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .state_in  (state_in),
    .state_out (state_out),
    .busy      (busy),
    .done      (done),
    .gen_count (gen_count),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] life_ref(input logic [W-1:0] b);
    logic [W-1:0] r;
    int n, nx, ny;
    r = '0;
    for (int y = 0; y < MAX_Y; y++) begin
      for (int x = 0; x < MAX_X; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            nx = x + dx;
            ny = y + dy;
            if (!(dx == 0 && dy == 0) && nx >= 0 && nx < MAX_X && ny >= 0 && ny < MAX_Y)
              if (b[ny*MAX_X + nx]) n++;
          end
        end
        r[y*MAX_X + x] = (n == 3) || (n == 2 && b[y*MAX_X + x]);
      end
    end
    return r;
  endfunction

  // ---------------- check helpers ----------------
  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_board(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    logic [W-1:0] diff;
    int first;
    checks++;
    diff = act ^ exp;
    if (diff != '0) begin
      failures++;
      first = -1;
      for (int i = W - 1; i >= 0; i--) if (diff[i]) first = i;
      $display("FAIL %s: first differing bit=%0d actual_bit=%0b actual_ones=%0d required_ones=%0d (t=%0t)",
               name, first, act[first], $countones(act), $countones(exp), $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] eb;
    logic [15:0]  eg;
    int           ec;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: actual=done required=no_done (t=%0t)", $time);
      end else begin
        eb = exp_q.pop_front();
        eg = exp_gen_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check_board("result", state_out, eb);
        check_val("gen_count", int'(gen_count), int'(eg));
        check_val("done_latency", cyc - ec, MAX_Y + 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int budget;
    budget = 500;
    @(negedge clk);
    while (busy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: actual=busy required=idle (t=%0t)", $time);
    end
  endtask

  task automatic expect_step(input logic [W-1:0] b, input int acc);
    model_gen = model_gen + 16'd1;
    exp_q.push_back(life_ref(b));
    exp_gen_q.push_back(model_gen);
    exp_cyc_q.push_back(acc);
  endtask

  // Pulse start for one edge with board b; the accepting edge is recorded for the latency check.
  task automatic step(input logic [W-1:0] b);
    wait_idle();
    state_in = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    expect_step(b, cyc);
  endtask

  task automatic drain();
    int budget;
    budget = 300;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      failures++;
      $display("FAIL drain: actual_pending=%0d required_pending=0 (t=%0t)", exp_q.size(), $time);
      exp_q.delete();
      exp_gen_q.delete();
      exp_cyc_q.delete();
    end
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rand_board();
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) b[i] = ($urandom_range(0, 3) == 0);
    return b;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] b, v;
    int acc;

    rst       = 1'b1;
    start     = 1'b0;
    state_in  = '0;
    model_gen = '0;

    // Reset takes priority over a simultaneous start.
    repeat (2) @(posedge clk);
    state_in = rand_board();
    start    = 1'b1;
    @(posedge clk);
    #1;
    check_val("reset_state_out_zero", int'(state_out != '0), 0);
    check_val("reset_busy", int'(busy), 0);
    check_val("reset_done", int'(done), 0);
    check_val("reset_gen_count", int'(gen_count), 0);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;

    // Blinker, horizontal to vertical.
    b = '0;
    b[330] = 1'b1; b[331] = 1'b1; b[332] = 1'b1;
    step(b);
    @(negedge clk);
    check_val("busy_during_run", int'(busy), 1);
    drain();
    v = '0;
    v[267] = 1'b1; v[331] = 1'b1; v[395] = 1'b1;
    check_board("blinker_vertical", state_out, v);
    check_val("busy_after_done", int'(busy), 0);
    check_val("done_single_pulse", int'(done), 0);

    // Blinker back to horizontal.
    step(v);
    drain();
    check_board("blinker_horizontal", state_out, b);

    // Border clipping at column 0.
    b = '0;
    b[0] = 1'b1; b[64] = 1'b1; b[128] = 1'b1;
    step(b);
    drain();
    v = '0;
    v[64] = 1'b1; v[65] = 1'b1;
    check_board("border_clip", state_out, v);

    // Still-life block, then an empty board.
    b = '0;
    b[0] = 1'b1; b[1] = 1'b1; b[64] = 1'b1; b[65] = 1'b1;
    step(b);
    drain();
    check_board("block_still", state_out, b);
    step('0);
    drain();
    check_board("empty_board", state_out, '0);

    // A start during RUN is ignored, and state_in changes during RUN are isolated.
    b = rand_board();
    step(b);
    repeat (10) @(negedge clk);
    start    = 1'b1;
    state_in = '1;
    @(negedge clk);
    start = 1'b0;
    check_val("busy_ignore_still_busy", int'(busy), 1);
    drain();
    repeat (5) @(negedge clk);
    check_val("busy_ignore_idle", int'(busy), 0);
    check_val("busy_ignore_gen", int'(gen_count), int'(model_gen));

    // Random boards.
    for (int k = 0; k < 6; k++) begin
      step(rand_board());
      drain();
    end

    // start held high re-triggers one edge after the cycle that shows done.
    wait_idle();
    b = rand_board();
    state_in = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    expect_step(b, acc);
    expect_step(b, acc + MAX_Y + 2);
    repeat (MAX_Y + 2) @(posedge clk);
    #1;
    start = 1'b0;
    check_val("held_start_retrigger_busy", int'(busy), 1);
    drain();

    // A reset mid-RUN aborts the generation.
    step(rand_board());
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    void'(exp_gen_q.pop_back());
    void'(exp_cyc_q.pop_back());
    model_gen = '0;
    check_val("midrun_rst_state_out", int'(state_out != '0), 0);
    check_val("midrun_rst_busy", int'(busy), 0);
    check_val("midrun_rst_gen", int'(gen_count), 0);
    check_val("midrun_rst_done", int'(done), 0);
    repeat (60) @(negedge clk);
    check_val("midrun_rst_stays_idle", int'(busy), 0);
    step(rand_board());
    drain();

    // Counter wrap from a preloaded 16'hFFFF.
    wait_idle();
    force dut.gen_count = 16'hFFFF;
    #1;
    release dut.gen_count;
    model_gen = 16'hFFFF;
    @(negedge clk);
    check_val("preload_gen", int'(gen_count), 16'hFFFF);
    step(rand_board());
    drain();
    check_val("gen_wrap_zero", int'(gen_count), 0);

    repeat (5) @(negedge clk);
    check_val("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit, in case anything above stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
